cnn_inference_sequencer: RTL and testbench

Top-level controller that runs the conv1→pool1→conv2→pool2→FC→argmax inference pipeline over a batch of images held in external pixel memory. Per image it pulses the pipeline reset, streams every pixel from memory into the pipeline's imagein/valid inputs, waits for the class index with a timeout, and hands the result out over a valid/ready port. It sits between the image buffer, the classifier top and the host/result consumer.

---
 rtl/cnn_inference_sequencer_if.sv | 36 +++
 rtl/cnn_inference_sequencer.sv | 154 +++++++++++++++
 tb/tb_cnn_inference_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_inference_sequencer_if.sv
// Signal bundle between the inference sequencer and its environment:
// batch control, pixel-memory read port, classifier pipeline and result port.
interface cnn_inference_sequencer_if #(
  parameter int MEM_AW = 18
);
  logic              start;
  logic [7:0]        num_images;
  logic [MEM_AW-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              pipe_reset;
  logic [15:0]       pipe_pixel;
  logic              pipe_valid;
  logic [4:0]        pipe_index;
  logic              pipe_index_valid;
  logic              result_valid;
  logic              result_ready;
  logic [3:0]        result_class;
  logic [7:0]        result_img;
  logic              timeout_err;

  modport master (
    input  start, num_images, base_addr, mem_rdata, pipe_index, pipe_index_valid, result_ready,
    output busy, done, mem_rd_en, mem_addr, pipe_reset, pipe_pixel, pipe_valid,
           result_valid, result_class, result_img, timeout_err
  );

  modport slave (
    output start, num_images, base_addr, mem_rdata, pipe_index, pipe_index_valid, result_ready,
    input  busy, done, mem_rd_en, mem_addr, pipe_reset, pipe_pixel, pipe_valid,
           result_valid, result_class, result_img, timeout_err
  );
endinterface

// File: rtl/cnn_inference_sequencer.sv
// Batch controller for the CNN classifier: per image it resets the pipeline,
// streams the pixels from memory, waits for the class index and emits it.
module cnn_inference_sequencer #(
  parameter int PIXELS     = 784,
  parameter int MEM_AW     = 18,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 65535,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  cnn_inference_sequencer_if.master  bus
);

  // One shared counter serves PRST, STREAM and WAIT, so it must fit the largest bound.
  localparam int PW  = $clog2(PIXELS + 1);
  localparam int RW  = $clog2(RST_CYCLES + 1);
  localparam int CW1 = (CNT_W > PW) ? CNT_W : PW;
  localparam int CW  = (CW1 > RW) ? CW1 : RW;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(PIXELS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PRST, STREAM, WAIT, EMIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [7:0]        num_q, num_d;
  logic [7:0]        img_q, img_d;
  logic [3:0]        class_q, class_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              pipe_reset_q, pipe_reset_d;
  logic              pipe_valid_q, pipe_valid_d;
  logic              rd_en;

  assign rd_en = (state_q == STREAM);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    num_d        = num_q;
    img_d        = img_q;
    class_d      = class_q;
    err_d        = err_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_d  = bus.num_images;
          addr_d = bus.base_addr;
          img_d  = 8'd0;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (bus.num_images == 8'd0) done_d = 1'b1;
          else                        state_d = PRST;
        end
      end
      PRST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        // The running address ends one past this image, i.e. on the next image's pixel 0.
        addr_d = addr_q + MEM_AW'(1);
        if (cnt_q == PIX_LAST) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (bus.pipe_index_valid) begin
          if (bus.pipe_index <= 5'd9) begin
            class_d = bus.pipe_index[3:0];
          end else begin
            class_d = 4'hF;
            err_d   = 1'b1;
          end
          state_d = EMIT;
        end else if (cnt_q == TO_LAST) begin
          class_d = 4'hF;
          err_d   = 1'b1;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (bus.result_ready) begin
          img_d = img_q + 8'd1;
          cnt_d = '0;
          if ((img_q + 8'd1) == num_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = PRST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pipe_reset_d = (state_d == PRST);
    pipe_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      num_q        <= 8'd0;
      img_q        <= 8'd0;
      class_q      <= 4'd0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      pipe_reset_q <= 1'b0;
      pipe_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      num_q        <= num_d;
      img_q        <= img_d;
      class_q      <= class_d;
      err_q        <= err_d;
      done_q       <= done_d;
      pipe_reset_q <= pipe_reset_d;
      pipe_valid_q <= pipe_valid_d;
    end
  end

  // The pipeline is held in reset for as long as this block is.
  assign bus.pipe_reset   = pipe_reset_q | reset;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.mem_rd_en    = rd_en;
  assign bus.mem_addr     = addr_q;
  assign bus.pipe_pixel   = bus.mem_rdata;
  assign bus.pipe_valid   = pipe_valid_q;
  assign bus.result_valid = (state_q == EMIT);
  assign bus.result_class = class_q;
  assign bus.result_img   = img_q;
  assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_cnn_inference_sequencer.sv
// Scoreboard bench for cnn_inference_sequencer with a small memory model and
// a classifier-pipeline model whose per-image answer is programmed by the test.
module tb_cnn_inference_sequencer;
  localparam int PIX  = 16;
  localparam int AW   = 18;
  localparam int RSTC = 2;
  localparam int TO   = 64;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cnn_inference_sequencer_if #(.MEM_AW(AW)) bus();

  cnn_inference_sequencer #(
    .PIXELS(PIX), .MEM_AW(AW), .RST_CYCLES(RSTC), .TIMEOUT(TO), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct { int img; int cls; int lat; } exp_t;
  exp_t        exp_q[$];
  int          cfg_q[$];
  logic [15:0] pix_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pv_cyc = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int prst_cnt = 0;
  int pix_total = 0;
  int stall_seen = 0;
  int stall_img = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory: data is the low 16 address bits, one cycle after the strobe.
  logic [15:0] mem_q = 16'h0;
  always @(posedge clk) if (bus.mem_rd_en) mem_q <= bus.mem_addr[15:0];
  assign bus.mem_rdata = mem_q;

  // Classifier model: checks the pixel stream and answers LAT cycles after the last pixel.
  logic        pvalid = 1'b0;
  logic [4:0]  pidx = 5'd0;
  logic [15:0] exp_pix = 16'h0;
  int          pcnt = 0;
  int          lat = 0;
  int          cur_cfg = -1;
  bit          armed = 1'b0;
  assign bus.pipe_index_valid = pvalid;
  assign bus.pipe_index       = pidx;

  always @(negedge clk) begin
    if (bus.pipe_reset) begin
      pcnt   = 0;
      armed  = 1'b0;
      pvalid = 1'b0;
    end else if (bus.pipe_valid) begin
      if (pcnt == 0) begin
        if (pix_q.size() > 0) exp_pix = pix_q.pop_front();
        else begin
          checks++;
          errors++;
          $display("FAIL unexpected_stream: got pixel 0x%0h expected no stream", bus.pipe_pixel);
        end
      end
      chk("pixel", {16'h0, bus.pipe_pixel}, {16'h0, exp_pix});
      exp_pix     = exp_pix + 16'd1;
      pcnt++;
      pix_total++;
      last_pv_cyc = cyc;
      if (pcnt == PIX) begin
        armed   = 1'b1;
        lat     = LAT;
        cur_cfg = (cfg_q.size() > 0) ? cfg_q.pop_front() : -1;
      end
    end else if (armed) begin
      if (lat > 0) lat--;
      else if (cur_cfg >= 0) begin
        pvalid = 1'b1;
        pidx   = cur_cfg[4:0];
      end
    end
  end

  // Result consumer: stalls 5 cycles on image stall_img, otherwise always ready.
  logic rdy = 1'b1;
  int   emit_cnt = 0;
  assign bus.result_ready = rdy;
  always @(posedge clk) begin
    #1;
    if (!bus.result_valid) emit_cnt = 0;
    else emit_cnt++;
    rdy = !(bus.result_valid && int'(bus.result_img) == stall_img && emit_cnt <= 5);
  end

  // Monitor: pops the scoreboard on each accepted result, checks hold-stability.
  bit         in_emit = 1'b0;
  logic [3:0] held_cls;
  logic [7:0] held_img;
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      done_cnt++;
      chk("busy_at_done", {31'h0, bus.busy}, 32'h0);
    end
    if (bus.mem_rd_en) rd_cnt++;
    if (bus.pipe_reset && !reset) prst_cnt++;
    if (!reset && bus.result_valid) begin
      if (!in_emit) begin
        in_emit = 1'b1;
        if (exp_q.size() > 0 && exp_q[0].lat >= 0)
          chk("timeout_latency", cyc - last_pv_cyc, exp_q[0].lat);
      end else begin
        chk("hold_class", {28'h0, bus.result_class}, {28'h0, held_cls});
        chk("hold_img", {24'h0, bus.result_img}, {24'h0, held_img});
      end
      held_cls = bus.result_class;
      held_img = bus.result_img;
      if (!bus.result_ready) stall_seen++;
      else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got img %0d class 0x%0h expected none",
                   bus.result_img, bus.result_class);
        end else begin
          e = exp_q.pop_front();
          $display("result img %0d class 0x%0h (expect img %0d class 0x%0h)",
                   bus.result_img, bus.result_class, e.img, e.cls);
          chk("result_img", {24'h0, bus.result_img}, e.img);
          chk("result_class", {28'h0, bus.result_class}, e.cls);
        end
        in_emit = 1'b0;
      end
    end else begin
      in_emit = 1'b0;
    end
  end

  task automatic do_start(input int n, input logic [AW-1:0] b);
    @(posedge clk) #1;
    bus.start      = 1'b1;
    bus.num_images = n[7:0];
    bus.base_addr  = b;
    @(posedge clk) #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got %0d done pulses expected %0d", done_cnt, target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.num_images = 8'd0;
    bus.base_addr  = '0;
    reset          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",         {31'h0, bus.busy}, 0);
    chk("rst_done",         {31'h0, bus.done}, 0);
    chk("rst_rd_en",        {31'h0, bus.mem_rd_en}, 0);
    chk("rst_pipe_valid",   {31'h0, bus.pipe_valid}, 0);
    chk("rst_result_valid", {31'h0, bus.result_valid}, 0);
    chk("rst_timeout_err",  {31'h0, bus.timeout_err}, 0);
    chk("rst_mem_addr",     {14'h0, bus.mem_addr}, 0);
    chk("rst_result_class", {28'h0, bus.result_class}, 0);
    chk("rst_result_img",   {24'h0, bus.result_img}, 0);
    chk("rst_pipe_reset",   {31'h0, bus.pipe_reset}, 1);
    @(posedge clk) #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_pipe_reset", {31'h0, bus.pipe_reset}, 0);

    // Single image with cycle-exact timing from the start pulse.
    exp_q.push_back('{0, 7, -1});
    cfg_q.push_back(7);
    pix_q.push_back(16'h0100);
    do_start(1, 18'h00100);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("t1_pipe_reset_c%0d", k), {31'h0, bus.pipe_reset}, (k <= 2));
      chk($sformatf("t1_rd_en_c%0d", k), {31'h0, bus.mem_rd_en}, (k >= 3 && k <= 18));
      if (k >= 3 && k <= 18) chk($sformatf("t1_addr_c%0d", k), {14'h0, bus.mem_addr}, 32'h100 + k - 3);
      chk($sformatf("t1_pipe_valid_c%0d", k), {31'h0, bus.pipe_valid}, (k >= 4 && k <= 19));
      chk($sformatf("t1_busy_c%0d", k), {31'h0, bus.busy}, 1);
    end
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_timeout_err", {31'h0, bus.timeout_err}, 0);
    chk("t1_pixel_total", pix_total, PIX);

    // Three images, consumer stall on image 1, start pulsed while busy.
    exp_q.push_back('{0, 3, -1});
    exp_q.push_back('{1, 9, -1});
    exp_q.push_back('{2, 0, -1});
    cfg_q.push_back(3); cfg_q.push_back(9); cfg_q.push_back(0);
    pix_q.push_back(16'h0200); pix_q.push_back(16'h0210); pix_q.push_back(16'h0220);
    stall_img = 1;
    do_start(3, 18'h00200);
    repeat (10) @(posedge clk);
    do_start(5, 18'h09000);
    wait_done(2);
    repeat (40) @(negedge clk);
    chk("t2_done_count", done_cnt, 2);
    chk("t2_busy_after", {31'h0, bus.busy}, 0);
    chk("t2_results_left", exp_q.size(), 0);
    chk("t2_stall_cycles", stall_seen, 5);
    chk("t2_streams_left", pix_q.size(), 0);
    chk("t2_pixel_total", pix_total, 4 * PIX);
    stall_img = -1;

    // Timeout on image 0 across the address wrap, then a normal image 1.
    exp_q.push_back('{0, 15, TO});
    exp_q.push_back('{1, 5, -1});
    cfg_q.push_back(-1); cfg_q.push_back(5);
    pix_q.push_back(16'hFFF8); pix_q.push_back(16'h0008);
    do_start(2, 18'h3FFF8);
    wait_done(3);
    repeat (2) @(negedge clk);
    chk("t3_timeout_err", {31'h0, bus.timeout_err}, 1);
    chk("t3_results_left", exp_q.size(), 0);

    // Out-of-range index is reported as error class.
    exp_q.push_back('{0, 15, -1});
    cfg_q.push_back(12);
    pix_q.push_back(16'h0040);
    do_start(1, 18'h00040);
    @(negedge clk);
    chk("t4_err_cleared_on_start", {31'h0, bus.timeout_err}, 0);
    wait_done(4);
    repeat (2) @(negedge clk);
    chk("t4_timeout_err", {31'h0, bus.timeout_err}, 1);
    chk("t4_results_left", exp_q.size(), 0);

    // Empty batch: immediate done, no activity, error flag cleared.
    begin
      int rd0, p0;
      rd0 = rd_cnt;
      p0  = prst_cnt;
      do_start(0, 18'h00123);
      @(negedge clk);
      chk("t5_done_pulse", {31'h0, bus.done}, 1);
      chk("t5_busy", {31'h0, bus.busy}, 0);
      repeat (5) @(negedge clk);
      chk("t5_done_count", done_cnt, 5);
      chk("t5_timeout_err", {31'h0, bus.timeout_err}, 0);
      chk("t5_no_reads", rd_cnt - rd0, 0);
      chk("t5_no_pipe_reset", prst_cnt - p0, 0);
    end

    // Reset in the middle of the stream, then a fresh full image.
    cfg_q.push_back(4);
    pix_q.push_back(16'h0500);
    do_start(1, 18'h00500);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    chk("t6_abort_busy", {31'h0, bus.busy}, 0);
    chk("t6_abort_rd_en", {31'h0, bus.mem_rd_en}, 0);
    chk("t6_abort_pipe_valid", {31'h0, bus.pipe_valid}, 0);
    chk("t6_abort_done", {31'h0, bus.done}, 0);
    cfg_q.delete();
    @(posedge clk) #1 reset = 1'b0;
    exp_q.push_back('{0, 4, -1});
    cfg_q.push_back(4);
    pix_q.push_back(16'h0500);
    do_start(1, 18'h00500);
    wait_done(6);
    repeat (3) @(negedge clk);
    chk("t6_done_count", done_cnt, 6);
    chk("t6_results_left", exp_q.size(), 0);
    chk("t6_streams_left", pix_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
